// File: rtl/spi_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module : spi_slave_fsm
// Desc   : SPI slave front end; MOSI frames -> 10-bit RAM words, RAM read
//          data -> MISO. Define SPI_SLAVE_ASSERT_EN for embedded assertions.
// Rev    : 1.0  initial release
// ============================================================================
module spi_slave_fsm #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int BIT_CNT_W = $clog2(WORD_W);
  localparam int TX_CNT_W  = $clog2(DATA_W + 1);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_chk_cmd   = 3'd1;
  localparam logic [2:0] c_write     = 3'd2;
  localparam logic [2:0] c_read_add  = 3'd3;
  localparam logic [2:0] c_read_data = 3'd4;

  localparam logic [BIT_CNT_W-1:0] c_last_bit = BIT_CNT_W'(WORD_W - 1);
  localparam logic [TX_CNT_W-1:0]  c_tx_bits  = TX_CNT_W'(DATA_W);

  logic [2:0]           r_state;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [WORD_W-1:0]    r_shift;
  logic [WORD_W-1:0]    r_rx_data;
  logic                 r_rx_valid;
  logic                 r_done;
  logic                 r_wait_tx;
  logic                 r_rd_addr_seen;
  logic [DATA_W-1:0]    r_tx_shift;
  logic [TX_CNT_W-1:0]  r_tx_cnt;
  logic                 r_miso;
  logic [WORD_W-1:0]    w_shift_next;

  assign w_shift_next = {r_shift[WORD_W-2:0], MOSI};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_idle;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_done         <= 1'b0;
      r_wait_tx      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == c_idle) begin
        r_miso <= 1'b0;
        if (!SS_n) begin
          r_state   <= c_chk_cmd;
          r_bit_cnt <= '0;
          r_shift   <= '0;
          r_done    <= 1'b0;
          r_wait_tx <= 1'b0;
          r_tx_cnt  <= '0;
        end
      end else if (SS_n || (r_state > c_read_data)) begin
        // Abort: partial word and any MISO burst are dropped; the read flag survives.
        r_state    <= c_idle;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_done     <= 1'b0;
        r_wait_tx  <= 1'b0;
        r_tx_shift <= '0;
        r_tx_cnt   <= '0;
        r_miso     <= 1'b0;
      end else if (r_state == c_chk_cmd) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= BIT_CNT_W'(1);
        if (!MOSI)
          r_state <= c_write;
        else if (r_rd_addr_seen)
          r_state <= c_read_data;
        else
          r_state <= c_read_add;
      end else if (!r_done) begin
        r_shift <= w_shift_next;
        if (r_bit_cnt == c_last_bit) begin
          r_rx_data  <= w_shift_next;
          r_rx_valid <= 1'b1;
          r_done     <= 1'b1;
          if (r_state == c_read_add) begin
            r_rd_addr_seen <= 1'b1;
          end else if (r_state == c_read_data) begin
            r_rd_addr_seen <= 1'b0;
            r_wait_tx      <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
      end else if (r_wait_tx) begin
        if (tx_valid) begin
          r_tx_shift <= tx_data;
          r_tx_cnt   <= c_tx_bits;
          r_wait_tx  <= 1'b0;
        end
      end else if (r_tx_cnt != '0) begin
        r_miso     <= r_tx_shift[DATA_W-1];
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
        r_tx_cnt   <= r_tx_cnt - TX_CNT_W'(1);
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_ASSERT_EN
  a_rx_valid_single: assert property (@(posedge clk) disable iff (rst)
    r_rx_valid |=> !r_rx_valid);
  cov_rx_valid_single: cover property (@(posedge clk) disable iff (rst)
    r_rx_valid ##1 !r_rx_valid);

  a_rx_valid_selected: assert property (@(posedge clk) disable iff (rst)
    r_rx_valid |-> !$past(SS_n));
  cov_rx_valid_selected: cover property (@(posedge clk) disable iff (rst)
    r_rx_valid && !$past(SS_n));

  // A high MISO must come from a burst step taken on the previous edge.
  a_miso_in_burst: assert property (@(posedge clk) disable iff (rst)
    r_miso |-> $past((r_state == c_read_data) && (r_tx_cnt != '0) && !SS_n));
  cov_miso_in_burst: cover property (@(posedge clk) disable iff (rst)
    r_miso);

  a_deselect_idle: assert property (@(posedge clk) disable iff (rst)
    SS_n |=> (r_state == c_idle));
  cov_deselect_idle: cover property (@(posedge clk) disable iff (rst)
    (SS_n && (r_state != c_idle)) ##1 (r_state == c_idle));
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_slave_fsm
// Desc   : Directed self-checking bench for spi_slave_fsm.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_slave_fsm;

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_chk_cmd   = 3'd1;
  localparam logic [2:0] c_write     = 3'd2;
  localparam logic [2:0] c_read_add  = 3'd3;
  localparam logic [2:0] c_read_data = 3'd4;

  logic       clk;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int total;
  int bad;

  spi_slave_fsm #(.WORD_W(10), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Sends nbits of word MSB first; abort_last raises SS_n on the last sampled bit.
  task automatic run_frame(input logic [9:0] word, input logic [2:0] exp_st,
                           input logic [9:0] prev_rx, input int nbits, input bit abort_last);
    bit complete;
    complete = (nbits == 10) && !abort_last;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    chk("state_chk_cmd", 16'(dut.r_state), 16'(c_chk_cmd));
    for (int i = 0; i < nbits; i++) begin
      MOSI = word[9-i];
      if (abort_last && (i == nbits - 1)) SS_n = 1'b1;
      tick();
      if ((i == 0) && !abort_last) chk("state_path", 16'(dut.r_state), 16'(exp_st));
      chk("miso_frame", 16'(MISO), 16'h0);
      if (complete && (i == 9)) begin
        chk("rx_valid_pulse", 16'(rx_valid), 16'h1);
        chk("rx_data_word", 16'(rx_data), 16'(word));
      end else begin
        chk("rx_valid_low", 16'(rx_valid), 16'h0);
        chk("rx_data_hold", 16'(rx_data), 16'(prev_rx));
      end
    end
    if (abort_last) chk("state_abort_last", 16'(dut.r_state), 16'(c_idle));
    if (complete) begin
      tick();
      chk("rx_valid_single", 16'(rx_valid), 16'h0);
      chk("rx_data_stable", 16'(rx_data), 16'(word));
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
    chk("state_idle", 16'(dut.r_state), 16'(c_idle));
    chk("miso_idle", 16'(MISO), 16'h0);
  endtask

  initial begin
    logic [7:0] pat;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    SS_n     = 1'b0;
    MOSI     = 1'b1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tick();
    chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("rst_rx_data", 16'(rx_data), 16'h0);
    chk("rst_state", 16'(dut.r_state), 16'(c_idle));
    chk("rst_seen", 16'(dut.r_rd_addr_seen), 16'h0);

    rst      = 1'b0;
    SS_n     = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick();

    // Write address and write data
    run_frame(10'h05A, c_write, 10'h000, 10, 1'b0);
    end_frame();
    run_frame(10'h1C3, c_write, 10'h05A, 10, 1'b0);
    chk("seen_after_wr", 16'(dut.r_rd_addr_seen), 16'h0);
    end_frame();

    // Read address, an intervening write, then read data
    run_frame(10'h25A, c_read_add, 10'h1C3, 10, 1'b0);
    chk("seen_set", 16'(dut.r_rd_addr_seen), 16'h1);
    end_frame();
    run_frame(10'h0A7, c_write, 10'h25A, 10, 1'b0);
    chk("seen_kept_by_wr", 16'(dut.r_rd_addr_seen), 16'h1);
    end_frame();
    run_frame(10'h300, c_read_data, 10'h0A7, 10, 1'b0);
    chk("seen_cleared", 16'(dut.r_rd_addr_seen), 16'h0);
    tick();
    chk("miso_wait", 16'(MISO), 16'h0);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    chk("miso_load_edge", 16'(MISO), 16'h0);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    pat      = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("miso_bit", 16'(MISO), 16'(pat[7-i]));
    end
    tick();
    chk("miso_after_burst", 16'(MISO), 16'h0);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tick();
    chk("miso_no_reload", 16'(MISO), 16'h0);
    tx_valid = 1'b0;
    end_frame();

    // Abort after 6 bits, then a clean frame
    run_frame(10'h3FF, c_read_add, 10'h300, 6, 1'b0);
    SS_n = 1'b1;
    tick();
    chk("abort_state", 16'(dut.r_state), 16'(c_idle));
    chk("abort_rx_valid", 16'(rx_valid), 16'h0);
    chk("abort_rx_data", 16'(rx_data), 16'h300);
    chk("abort_seen", 16'(dut.r_rd_addr_seen), 16'h0);
    run_frame(10'h0F0, c_write, 10'h300, 10, 1'b0);
    end_frame();

    // SS_n rises on the same edge as the 10th bit
    run_frame(10'h0AB, c_write, 10'h0F0, 10, 1'b1);
    tick();
    chk("abort10_rx_valid", 16'(rx_valid), 16'h0);
    chk("abort10_rx_data", 16'(rx_data), 16'h0F0);

    // Stray tx_valid during a write frame
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    run_frame(10'h155, c_write, 10'h0F0, 10, 1'b0);
    tick();
    chk("stray_miso", 16'(MISO), 16'h0);
    tx_valid = 1'b0;
    end_frame();

    // Reset in the middle of a MISO burst
    run_frame(10'h2AA, c_read_add, 10'h155, 10, 1'b0);
    end_frame();
    run_frame(10'h3AA, c_read_data, 10'h2AA, 10, 1'b0);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    chk("burst_active", 16'(MISO), 16'h1);
    rst = 1'b1;
    tick();
    chk("mid_rst_miso", 16'(MISO), 16'h0);
    chk("mid_rst_rx_valid", 16'(rx_valid), 16'h0);
    chk("mid_rst_state", 16'(dut.r_state), 16'(c_idle));
    chk("mid_rst_seen", 16'(dut.r_rd_addr_seen), 16'h0);
    chk("mid_rst_rx_data", 16'(rx_data), 16'h0);
    rst  = 1'b0;
    SS_n = 1'b1;
    tick();
    chk("post_rst_miso", 16'(MISO), 16'h0);
    run_frame(10'h05A, c_write, 10'h000, 10, 1'b0);
    end_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
